mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Single-outstanding controller between a valid/ready requester
//            and a synchronous single-port memory with registered address,
//            write strobe and write data. Reads take two cycles to a held
//            response; writes take one busy cycle.
// Ports    : clk, rst_n (async, active-low)
//            req_valid/req_ready/req_we/req_addr/req_wdata  - request side
//            req_be (only with MEM_ACCESS_CTRL_BYTE_WRITE_EN) - byte enables
//            rsp_valid/rsp_ready/rsp_rdata                  - read response
//            mem_A/mem_W/mem_D (registered), mem_Q          - memory side
// Options  : MEM_ACCESS_CTRL_BYTE_WRITE_EN adds per-byte writes; partial
//            writes are done as read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int ADDR = 16,
  parameter int WORD = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR-1:0]   req_addr,
  input  logic [WORD-1:0]   req_wdata,
`ifdef MEM_ACCESS_CTRL_BYTE_WRITE_EN
  input  logic [WORD/8-1:0] req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD-1:0]   rsp_rdata,
  output logic [ADDR-1:0]   mem_A,
  output logic              mem_W,
  output logic [WORD-1:0]   mem_D,
  input  logic [WORD-1:0]   mem_Q
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_WR      = 3'd1;
  localparam logic [2:0] c_RD      = 3'd2;
  localparam logic [2:0] c_CAP     = 3'd3;
  localparam logic [2:0] c_RESP    = 3'd4;
`ifdef MEM_ACCESS_CTRL_BYTE_WRITE_EN
  localparam logic [2:0] c_RMW_RD  = 3'd5;
  localparam logic [2:0] c_RMW_CAP = 3'd6;
  localparam int         c_NBYTE   = WORD / 8;
`endif

  logic [2:0]      state_q, state_d;
  logic            ready_q, ready_d;
  logic [ADDR-1:0] mem_a_q, mem_a_d;
  logic            mem_w_q, mem_w_d;
  logic [WORD-1:0] mem_d_q, mem_d_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [WORD-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            w_accept;

`ifdef MEM_ACCESS_CTRL_BYTE_WRITE_EN
  // Partial-write operands are latched at acceptance because the requester
  // may change its inputs while the read half of the RMW is in flight.
  logic [c_NBYTE-1:0] be_q, be_d;
  logic [WORD-1:0]    wdata_q, wdata_d;
  logic [WORD-1:0]    w_merged;

  for (genvar b = 0; b < c_NBYTE; b++) begin : g_merge
    assign w_merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : mem_Q[8*b +: 8];
  end
`endif

  // ready_q is registered so it stays low throughout reset and rises on the
  // first edge after release, which also rules out accepting on that edge.
  assign w_accept = req_valid & ready_q;

  always_comb begin
    state_d     = state_q;
    mem_a_d     = mem_a_q;
    mem_d_d     = mem_d_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_ACCESS_CTRL_BYTE_WRITE_EN
    be_d        = be_q;
    wdata_d     = wdata_q;
`endif
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          if (req_we) begin
`ifdef MEM_ACCESS_CTRL_BYTE_WRITE_EN
            if (&req_be) begin
              mem_a_d = req_addr;
              mem_d_d = req_wdata;
              state_d = c_WR;
            end else if (|req_be) begin
              mem_a_d = req_addr;
              be_d    = req_be;
              wdata_d = req_wdata;
              state_d = c_RMW_RD;
            end
            // No enabled bytes: accepted and dropped, memory untouched.
`else
            mem_a_d = req_addr;
            mem_d_d = req_wdata;
            state_d = c_WR;
`endif
          end else begin
            mem_a_d = req_addr;
            state_d = c_RD;
          end
        end
      end
      c_WR:   state_d = c_IDLE;
      c_RD:   state_d = c_CAP;   // memory samples mem_A at this edge
      c_CAP: begin
        rsp_rdata_d = mem_Q;
        rsp_valid_d = 1'b1;
        state_d     = c_RESP;
      end
      c_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = c_IDLE;
        end
      end
`ifdef MEM_ACCESS_CTRL_BYTE_WRITE_EN
      c_RMW_RD:  state_d = c_RMW_CAP;
      c_RMW_CAP: begin
        mem_d_d = w_merged;
        state_d = c_WR;
      end
`endif
      default: state_d = c_IDLE;
    endcase
    ready_d = (state_d == c_IDLE);
    mem_w_d = (state_d == c_WR);
  end

  // Asynchronous clear of mem_w_q cancels an in-flight write the moment
  // reset asserts, before the memory's next sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= c_IDLE;
      ready_q     <= 1'b0;
      mem_a_q     <= '0;
      mem_w_q     <= 1'b0;
      mem_d_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEM_ACCESS_CTRL_BYTE_WRITE_EN
      be_q        <= '0;
      wdata_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      mem_a_q     <= mem_a_d;
      mem_w_q     <= mem_w_d;
      mem_d_q     <= mem_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef MEM_ACCESS_CTRL_BYTE_WRITE_EN
      be_q        <= be_d;
      wdata_q     <= wdata_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign mem_A     = mem_a_q;
  assign mem_W     = mem_w_q;
  assign mem_D     = mem_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire
